// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
//
// Multi-cycle multiply/divide unit that owns the HI/LO register pair.
// An issue pulse starts mult/multu/div/divu/madd/msub. The 64-bit result is
// computed at the issue edge, held in a pending register, and copied into
// HI/LO once the busy countdown expires. mthi/mtlo writes land directly
// when the unit is idle and no operation is being issued.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous reset, active low (0 = reset)
//   Start_MD_I   one-cycle issue pulse from the E-stage instruction
//   Op_MD_I      0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 msub, 6-7 reserved
//   A_MD_I       rs operand
//   B_MD_I       rt operand
//   HiWr_MD_I    mthi: HI <= WData_MD_I
//   LoWr_MD_I    mtlo: LO <= WData_MD_I
//   WData_MD_I   mthi/mtlo data
//   Busy_MD_O    Start_MD_I | busy state, to the stall controller
//   HI_MD_O      HI register
//   LO_MD_O      LO register
// ---------------------------------------------------------------------------
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start_MD_I,
   input  logic [2:0]  Op_MD_I,
   input  logic [31:0] A_MD_I,
   input  logic [31:0] B_MD_I,
   input  logic        HiWr_MD_I,
   input  logic        LoWr_MD_I,
   input  logic [31:0] WData_MD_I,
   output logic        Busy_MD_O,
   output logic [31:0] HI_MD_O,
   output logic [31:0] LO_MD_O
);

   // The counter must hold the larger of the two reload values.
   localparam int MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CntW      = $clog2(MaxCycles + 1);

   localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
   localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

   localparam logic [2:0] OpMult  = 3'd0;
   localparam logic [2:0] OpMultu = 3'd1;
   localparam logic [2:0] OpDiv   = 3'd2;
   localparam logic [2:0] OpDivu  = 3'd3;
   localparam logic [2:0] OpMadd  = 3'd4;
   localparam logic [2:0] OpMsub  = 3'd5;

   typedef enum logic {
      IDLE,
      BUSY
   } mdState_t;

   mdState_t        stateQ, stateNext;
   logic [CntW-1:0] cntQ, cntNext;
   logic [31:0]     hiQ, loQ;
   logic [63:0]     pendingQ;

   logic            validOp;
   logic            isDiv;
   logic            loadPending;
   logic            commit;
   logic            writeHi;
   logic            writeLo;

   logic [63:0]     hiLoQ;
   logic [63:0]     aSext, bSext;
   logic [63:0]     prodSigned, prodUnsigned;
   logic [31:0]     absA, absB, sDivisor, uDivisor;
   logic [31:0]     quotMag, remMag, sQuot, sRem;
   logic [31:0]     uQuot, uRem;
   logic [63:0]     opResult;

   assign hiLoQ   = {hiQ, loQ};
   assign validOp = (Op_MD_I < 3'd6);
   assign isDiv   = (Op_MD_I == OpDiv) || (Op_MD_I == OpDivu);

   // Multiply: the low 64 bits of the product of sign-extended operands equal
   // the signed 32x32 product, so one 64-bit multiply covers mult/madd/msub.
   always_comb begin
      aSext        = {{32{A_MD_I[31]}}, A_MD_I};
      bSext        = {{32{B_MD_I[31]}}, B_MD_I};
      prodSigned   = aSext * bSext;
      prodUnsigned = {32'd0, A_MD_I} * {32'd0, B_MD_I};
   end

   // Divide: signed division runs on magnitudes and fixes the signs after,
   // giving a truncate-toward-zero quotient and a remainder signed like A.
   // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
   // A zero divisor is swapped for 1 only to keep the arithmetic defined; the
   // result is discarded in that case.
   always_comb begin
      absA     = A_MD_I[31] ? (~A_MD_I + 32'd1) : A_MD_I;
      absB     = B_MD_I[31] ? (~B_MD_I + 32'd1) : B_MD_I;
      sDivisor = (B_MD_I == 32'd0) ? 32'd1 : absB;
      uDivisor = (B_MD_I == 32'd0) ? 32'd1 : B_MD_I;
      quotMag  = absA / sDivisor;
      remMag   = absA % sDivisor;
      sQuot    = (A_MD_I[31] ^ B_MD_I[31]) ? (~quotMag + 32'd1) : quotMag;
      sRem     = A_MD_I[31] ? (~remMag + 32'd1) : remMag;
      uQuot    = A_MD_I / uDivisor;
      uRem     = A_MD_I % uDivisor;
   end

   // Select the value that will land in {HI,LO}. Division by zero keeps the
   // current HI/LO, which cannot change while busy because mthi/mtlo are
   // blocked then, so committing the snapshot leaves them untouched.
   always_comb begin
      opResult = hiLoQ;
      case (Op_MD_I)
         OpMult:  opResult = prodSigned;
         OpMultu: opResult = prodUnsigned;
         OpDiv:   opResult = (B_MD_I == 32'd0) ? hiLoQ : {sRem, sQuot};
         OpDivu:  opResult = (B_MD_I == 32'd0) ? hiLoQ : {uRem, uQuot};
         OpMadd:  opResult = hiLoQ + prodSigned;
         OpMsub:  opResult = hiLoQ - prodSigned;
         default: opResult = hiLoQ;
      endcase
   end

   // Next-state logic. A valid issue in IDLE loads the countdown with N-1 so
   // the unit spends exactly N cycles in BUSY; the commit happens on the edge
   // that leaves BUSY with the counter at zero.
   always_comb begin
      stateNext   = stateQ;
      cntNext     = cntQ;
      loadPending = 1'b0;
      commit      = 1'b0;
      case (stateQ)
         IDLE: begin
            if (Start_MD_I && validOp) begin
               loadPending = 1'b1;
               cntNext     = isDiv ? DivLoad : MultLoad;
               stateNext   = BUSY;
            end
         end
         BUSY: begin
            if (cntQ == '0) begin
               commit    = 1'b1;
               stateNext = IDLE;
            end else begin
               cntNext = cntQ - CntW'(1);
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // mthi/mtlo are accepted only in a quiet idle cycle; any Start, even with
   // a reserved op, blocks them.
   assign writeHi = (stateQ == IDLE) && !Start_MD_I && HiWr_MD_I;
   assign writeLo = (stateQ == IDLE) && !Start_MD_I && LoWr_MD_I;

   // State, countdown and pending result registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ   <= IDLE;
         cntQ     <= '0;
         pendingQ <= '0;
      end else begin
         stateQ <= stateNext;
         cntQ   <= cntNext;
         if (loadPending) begin
            pendingQ <= opResult;
         end
      end
   end

   // HI/LO architectural registers: operation commit takes priority, though
   // commit and direct writes can never coincide since writes need IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hiQ <= '0;
         loQ <= '0;
      end else begin
         if (commit) begin
            hiQ <= pendingQ[63:32];
         end else if (writeHi) begin
            hiQ <= WData_MD_I;
         end
         if (commit) begin
            loQ <= pendingQ[31:0];
         end else if (writeLo) begin
            loQ <= WData_MD_I;
         end
      end
   end

   assign Busy_MD_O = Start_MD_I | (stateQ == BUSY);
   assign HI_MD_O   = hiQ;
   assign LO_MD_O   = loQ;

endmodule
